instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage that sits directly upstream of the decode/immediateGenerator path. It owns the program counter, issues word requests to instruction memory with a ready handshake, and presents each fetched instruction with its PC to decode. It also accepts branch/jump redirects and a decode stall, and traps misaligned redirect targets and unresponsive memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
TIMEOUT, 16, maximum cycles imem_req may stay high without imem_ready before a fetch fault; valid range 2..255.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address, always equal to internal pc
imem_ready  input  1  memory has valid data for imem_addr this cycle
imem_rdata  input  32  instruction word, sampled only when imem_req && imem_ready
stall  input  1  decode cannot accept; hold current instruction
redirect_valid  input  1  branch/jump taken; load redirect_target
redirect_target  input  32  new PC
instr_valid  output  1  instr/instr_pc hold a live instruction
instr  output  32  instruction word to decode and immediate generator
instr_pc  output  32  address of instr
fault  output  1  sticky fault indicator
fault_cause  output  2  01 misaligned redirect, 10 fetch timeout, 00 none

Behaviour:
- Reset (rst_n==0 at an edge): pc=RESET_PC, state=IDLE, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0, fault=0, fault_cause=00, timeout counter=0. imem_req=0 while in reset and in IDLE.
- Reset has priority over everything; asserting it mid-request abandons the request; any imem_ready in that cycle is ignored.
- States: IDLE -> FETCH unconditionally on the first edge after reset release. FETCH -> FAULT on misaligned redirect or timeout. FAULT is terminal until reset.
- imem_req = (state==FETCH) && !redirect_valid && !(instr_valid && stall). imem_addr = pc in every state.
- Accept: imem_req && imem_ready at an edge -> instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0). Latency: data presented with ready in cycle N is on instr in cycle N+1. Back-to-back accepts give one instruction per cycle.
- Consume: instr_valid && !stall at an edge with no new accept -> instr_valid<=0; instr/instr_pc retain their values.
- Stall: instr_valid && stall -> instr, instr_pc, instr_valid, pc frozen; no request issued. stall while instr_valid==0 has no effect.
- Redirect (FETCH, redirect_valid=1): highest priority after reset. Overrides stall and any concurrent ready. instr_valid<=0, timeout counter<=0. If redirect_target[1:0]==00: pc<=redirect_target and fetching resumes next cycle. Otherwise: pc unchanged, state<=FAULT, fault<=1, fault_cause<=01.
- Timeout: counter increments each cycle imem_req=1 && imem_ready=0 and clears on accept, redirect, or imem_req=0. When counter reaches TIMEOUT-1 while still unanswered: state<=FAULT, fault<=1, fault_cause<=10 (fault asserts on the edge ending the TIMEOUT-th unanswered cycle).
- FAULT: imem_req=0, instr_valid<=0, redirect/stall/ready ignored, fault and fault_cause held.
- redirect_valid in IDLE is ignored.

Test Plan:
- Reset then memory always ready returning 32'hFCE08713, 32'h00000013 -> imem_addr 0, 4, 8; instr_valid rises at cycle 2 after reset release; instr=FCE08713 with instr_pc=0, then 00000013 with instr_pc=4.
- stall=1 for 3 cycles while instr_pc=4 is valid -> instr/instr_pc unchanged, imem_req=0, pc=8 held; stall drop -> next accept at address 8.
- redirect_valid with target 32'h0000_0100 and a simultaneous imem_ready and stall -> rdata discarded, instr_valid=0 next cycle, following request at 0x100.
- redirect_target=32'h0000_0102 -> fault=1, fault_cause=01, imem_req=0 forever; a later valid redirect is ignored until rst_n pulse, then fetch restarts at RESET_PC.
- imem_ready held low with TIMEOUT=16 -> fault stays 0 for 15 cycles, asserts with cause 10 after the 16th; ready arriving on cycle 15 gives a normal accept and no fault.
- rst_n low for one cycle mid-stream at pc=0x20 -> all outputs return to reset values, instr=00000013; fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch stage: PC, imem handshake, redirect, fault trapping
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   imem_req/addr           word fetch request to instruction memory (addr is always the PC)
//   imem_ready/rdata        memory answer; rdata sampled only when req && ready
//   stall                   decode cannot accept; hold the presented instruction
//   redirect_valid/target   taken branch/jump; load a new PC
//   instr_valid/instr/pc    instruction presented to decode
//   fault/fault_cause       sticky trap: 01 misaligned redirect, 10 fetch timeout
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic [7:0]  r_tcnt;

  logic w_req;
  logic w_accept;
  logic w_misaligned;
  logic w_timeout;

  // Gating with rst_n keeps the request low during a reset cycle even though
  // the state register still holds FETCH until the edge.
  assign w_req        = rst_n && (r_state == S_FETCH) && !redirect_valid
                        && !(r_instr_valid && stall);
  assign w_accept     = w_req && imem_ready;
  assign w_misaligned = redirect_target[1:0] != 2'b00;
  // Counter holds the number of unanswered cycles already elapsed, so hitting
  // TIMEOUT-1 while still unanswered means this is the TIMEOUT-th one.
  assign w_timeout    = w_req && !imem_ready && (r_tcnt == TO_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = S_FETCH;
      S_FETCH: begin
        if ((redirect_valid && w_misaligned) || w_timeout) begin
          w_state_nxt = S_FAULT;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= NOP;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
      r_tcnt        <= 8'h0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (redirect_valid) begin
            // Redirect wins over stall and over any concurrent ready.
            r_instr_valid <= 1'b0;
            r_tcnt        <= 8'h0;
            if (!w_misaligned) begin
              r_pc <= redirect_target;
            end else begin
              r_fault       <= 1'b1;
              r_fault_cause <= 2'b01;
            end
          end else if (w_accept) begin
            r_instr       <= imem_rdata;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 32'd4;
            r_tcnt        <= 8'h0;
          end else begin
            // Consume: decode took the instruction and nothing new arrived.
            if (r_instr_valid && !stall) begin
              r_instr_valid <= 1'b0;
            end
            if (w_req) begin
              if (w_timeout) begin
                r_fault       <= 1'b1;
                r_fault_cause <= 2'b10;
              end else begin
                r_tcnt <= r_tcnt + 8'd1;
              end
            end else begin
              r_tcnt <= 8'h0;
            end
          end
        end
        S_FAULT: begin
          r_instr_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;

endmodule
